// File: rtl/hash_request_tx_if.sv
// Host command, table request/response and flush signals of the hash-table transmit path.
interface hash_request_tx_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [1:0]            cmd_op_i;
    logic [DATA_WIDTH-3:0] cmd_payload_i;
    logic                  req_valid_o;
    logic                  req_ready_i;
    logic [DATA_WIDTH-1:0] req_data_o;
    logic                  rsp_valid_i;
    logic [DATA_WIDTH-1:0] rsp_data_i;
    logic                  res_valid_o;
    logic [DATA_WIDTH-3:0] res_data_o;
    logic                  flush_i;
    logic                  flush_done_o;
    logic [CW-1:0]         outstanding_o;
    logic                  rsp_err;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_payload_i, req_ready_i, rsp_valid_i, rsp_data_i, flush_i,
        input  cmd_ready_o, req_valid_o, req_data_o, res_valid_o, res_data_o, flush_done_o,
               outstanding_o, rsp_err
    );
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_payload_i, req_ready_i, rsp_valid_i, rsp_data_i, flush_i,
        output cmd_ready_o, req_valid_o, req_data_o, res_valid_o, res_data_o, flush_done_o,
               outstanding_o, rsp_err
    );
endinterface

// File: rtl/hash_request_tx.sv
// Hash-table command transmitter: command FIFO, read-credit limiter, response return and drain FSM.
module hash_request_tx #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic              clk,
    input logic              reset,
    hash_request_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  err, rdy_en;
    logic                  fifo_full, fifo_empty, cmd_ready, req_valid;
    logic                  push, pop, rd_issue, rd_block, rsp_drop;
    logic [DATA_WIDTH-1:0] head;
    logic                  res_valid;
    logic [DATA_WIDTH-3:0] res_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];

    // A read at the credit limit stalls the head; only a response can lift it, so valid never drops.
    assign rd_block   = (head[DATA_WIDTH-1 -: 2] == OP_RD) && (cnt == CW'(MAX_OUTSTANDING));
    assign req_valid  = !fifo_empty && !rd_block;
    // rdy_en keeps cmd_ready low through reset while staying a function of flops only.
    assign cmd_ready  = rdy_en && !fifo_full && (state == IDLE);

    assign push     = bus.cmd_valid_i && cmd_ready && (bus.cmd_op_i != OP_NOP);
    assign pop      = req_valid && bus.req_ready_i;
    assign rd_issue = pop && (head[DATA_WIDTH-1 -: 2] == OP_RD);
    assign rsp_drop = bus.rsp_valid_i && !rd_issue && (cnt == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.cmd_op_i, bus.cmd_payload_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            rdy_en    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            state     <= IDLE;
        end else begin
            rdy_en    <= 1'b1;
            state     <= state_nxt;
            res_valid <= bus.rsp_valid_i;
            res_data  <= bus.rsp_data_i[DATA_WIDTH-3:0];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rd_issue && !bus.rsp_valid_i)
                cnt <= cnt + 1'b1;
            else if (!rd_issue && bus.rsp_valid_i && cnt != '0)
                cnt <= cnt - 1'b1;
            if (rsp_drop) err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.flush_i) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.req_valid_o   = req_valid;
    assign bus.req_data_o    = head;
    assign bus.res_valid_o   = res_valid;
    assign bus.res_data_o    = res_data;
    assign bus.flush_done_o  = (state == DONE);
    assign bus.outstanding_o = cnt;
    assign bus.rsp_err       = err;
endmodule

// File: tb/tb_hash_request_tx.sv
// Directed bench for hash_request_tx: inputs change and outputs are checked on the falling edge.
module tb_hash_request_tx;
    localparam int DW = 32;
    localparam int MO = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   pushed;
    int   guard;

    hash_request_tx_if #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

    hash_request_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(MO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] op, input logic [DW-3:0] pl);
        bus.cmd_valid_i   = v;
        bus.cmd_op_i      = op;
        bus.cmd_payload_i = pl;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        set_cmd(1'b0, 2'b00, '0);
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_data_i  = '0;
        bus.flush_i     = 1'b0;

        // 1: reset state, single write
        tick();
        chk("rst_cmd_ready", bus.cmd_ready_o, 0);
        chk("rst_req_valid", bus.req_valid_o, 0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        chk("rst_res_valid", bus.res_valid_o, 0);
        chk("rst_flush_done", bus.flush_done_o, 0);
        reset = 1'b1;
        tick();
        chk("t1_cmd_ready", bus.cmd_ready_o, 1);
        bus.req_ready_i = 1'b1;
        set_cmd(1'b1, 2'b10, 30'h0000_0ABC);
        tick();
        set_cmd(1'b0, 2'b00, '0);
        chk("t1_req_valid", bus.req_valid_o, 1);
        chk("t1_req_data", bus.req_data_o, 64'h8000_0ABC);
        tick();
        chk("t1_empty", bus.req_valid_o, 0);

        // 2: fill FIFO with table stalled, then release
        bus.req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 2'b10, 30'(i + 1));
            chk($sformatf("t2_cmd_ready%0d", i), bus.cmd_ready_o, (i < 4) ? 1 : 0);
            tick();
        end
        set_cmd(1'b0, 2'b00, '0);
        bus.req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_valid%0d", i), bus.req_valid_o, 1);
            chk($sformatf("t2_data%0d", i), bus.req_data_o, 64'h8000_0000 + 64'(i + 1));
            tick();
        end
        chk("t2_drained", bus.req_valid_o, 0);

        // 3: nine reads, credit limit of eight
        pushed = 0;
        guard  = 0;
        while (pushed < 9 && guard < 60) begin
            set_cmd(1'b1, 2'b01, 30'(pushed));
            if (bus.cmd_ready_o) pushed++;
            guard++;
            tick();
        end
        set_cmd(1'b0, 2'b00, '0);
        chk("t3_pushed", 64'(pushed), 9);
        repeat (6) tick();
        chk("t3_outstanding8", bus.outstanding_o, 8);
        chk("t3_blocked", bus.req_valid_o, 0);
        chk("t3_head", bus.req_data_o, 64'h4000_0008);
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'h0;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t3_res_valid", bus.res_valid_o, 1);
        chk("t3_outstanding7", bus.outstanding_o, 7);
        chk("t3_unblocked", bus.req_valid_o, 1);
        tick();
        chk("t3_outstanding_back8", bus.outstanding_o, 8);
        chk("t3_empty", bus.req_valid_o, 0);

        // 4: read issue and response in the same cycle, then drain credits
        set_cmd(1'b1, 2'b01, 30'h77);
        tick();
        set_cmd(1'b0, 2'b00, '0);
        chk("t4_blocked", bus.req_valid_o, 0);
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'h12;
        tick();
        chk("t4_valid", bus.req_valid_o, 1);
        bus.rsp_data_i = 32'hC000_0055;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t4_outstanding_same", bus.outstanding_o, 7);
        chk("t4_res_valid", bus.res_valid_o, 1);
        chk("t4_res_data", bus.res_data_o, 64'h55);
        bus.rsp_valid_i = 1'b1;
        repeat (7) tick();
        bus.rsp_valid_i = 1'b0;
        chk("t4_outstanding0", bus.outstanding_o, 0);
        chk("t4_err_clear", bus.rsp_err, 0);
        bus.rsp_valid_i = 1'b1;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t4_no_underflow", bus.outstanding_o, 0);
        chk("t4_err_set", bus.rsp_err, 1);

        // 5: nop is dropped; flush waits for queue and last response
        set_cmd(1'b1, 2'b00, 30'h5);
        tick();
        set_cmd(1'b0, 2'b00, '0);
        chk("t5_nop_a", bus.req_valid_o, 0);
        tick();
        chk("t5_nop_b", bus.req_valid_o, 0);
        bus.req_ready_i = 1'b0;
        set_cmd(1'b1, 2'b01, 30'h11);
        tick();
        set_cmd(1'b1, 2'b10, 30'h22);
        tick();
        set_cmd(1'b0, 2'b00, '0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("t5_enq_blocked", bus.cmd_ready_o, 0);
        chk("t5_done_early0", bus.flush_done_o, 0);
        bus.req_ready_i = 1'b1;
        tick();
        tick();
        chk("t5_queue_empty", bus.req_valid_o, 0);
        chk("t5_outstanding1", bus.outstanding_o, 1);
        tick();
        chk("t5_done_early1", bus.flush_done_o, 0);
        bus.rsp_valid_i = 1'b1;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t5_outstanding0", bus.outstanding_o, 0);
        chk("t5_done_early2", bus.flush_done_o, 0);
        tick();
        chk("t5_done_pulse", bus.flush_done_o, 1);
        tick();
        chk("t5_done_low", bus.flush_done_o, 0);
        chk("t5_ready_back", bus.cmd_ready_o, 1);

        // 6: reset in the middle of a burst
        set_cmd(1'b1, 2'b01, 30'h33);
        tick();
        set_cmd(1'b0, 2'b00, '0);
        tick();
        bus.req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 2'b10, 30'(i + 40));
            tick();
        end
        set_cmd(1'b0, 2'b00, '0);
        chk("t6_pre_valid", bus.req_valid_o, 1);
        chk("t6_pre_outstanding", bus.outstanding_o, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", bus.req_valid_o, 0);
        chk("t6_rst_outstanding", bus.outstanding_o, 0);
        chk("t6_rst_ready", bus.cmd_ready_o, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_ready", bus.cmd_ready_o, 1);
        chk("t6_valid", bus.req_valid_o, 0);
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'h3FF;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t6_res_valid", bus.res_valid_o, 1);
        chk("t6_res_data", bus.res_data_o, 64'h3FF);
        chk("t6_outstanding", bus.outstanding_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
